// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one
// GROUP-bit lookahead slice and passes its carry to the next stage.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   sub=0: a+b+cin   sub=1: a-b (cin ignored)
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = WIDTH / GROUP;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Global stall: the whole pipe moves only when the output slot frees.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign b_eff = b ^ {WIDTH{sub}};
    assign c_eff = sub | cin;

    genvar j;
    generate
        for (j = 0; j < L; j++) begin : stg
            localparam int LO = j * GROUP;
            localparam int HI = LO + GROUP;

            // Operand bits not yet consumed, this stage's slice at the bottom.
            logic [WIDTH-LO-1:0] ua;
            logic [WIDTH-LO-1:0] ub;
            logic                ci;
            logic                vi;
            logic [HI-1:0]       s_d;

            logic [GROUP-1:0]    g;
            logic [GROUP-1:0]    p;
            logic [GROUP-1:0]    ss;
            logic [GROUP:0]      cc;

            logic                v_q;
            logic                c_q;
            logic [HI-1:0]       s_q;

            if (j == 0) begin : head
                assign ua  = a;
                assign ub  = b_eff;
                assign ci  = c_eff;
                assign vi  = in_valid;
                assign s_d = ss;
            end else begin : link
                assign ua  = stg[j-1].tail.a_q;
                assign ub  = stg[j-1].tail.b_q;
                assign ci  = stg[j-1].c_q;
                assign vi  = stg[j-1].v_q;
                assign s_d = {ss, stg[j-1].s_q};
            end

            assign g = ua[GROUP-1:0] & ub[GROUP-1:0];
            assign p = ua[GROUP-1:0] ^ ub[GROUP-1:0];

            // Flat lookahead: every carry is a sum of generate/propagate
            // products straight from the slice inputs, no ripple chain.
            always_comb begin
                logic t;
                logic acc;
                t     = 1'b0;
                acc   = 1'b0;
                cc    = '0;
                cc[0] = ci;
                for (int i = 0; i < GROUP; i++) begin
                    acc = 1'b0;
                    for (int k = 0; k <= i; k++) begin
                        t = g[k];
                        for (int m = k + 1; m <= i; m++) begin
                            t = t & p[m];
                        end
                        acc = acc | t;
                    end
                    t = ci;
                    for (int m = 0; m <= i; m++) begin
                        t = t & p[m];
                    end
                    cc[i+1] = acc | t;
                end
            end

            assign ss = p ^ cc[GROUP-1:0];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (advance) begin
                    v_q <= vi;
                    c_q <= cc[GROUP];
                    s_q <= s_d;
                end
            end

            if (j < L - 1) begin : tail
                logic [WIDTH-HI-1:0] a_q;
                logic [WIDTH-HI-1:0] b_q;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance) begin
                        a_q <= ua[WIDTH-LO-1:GROUP];
                        b_q <= ub[WIDTH-LO-1:GROUP];
                    end
                end
            end

            if (j == L - 1) begin : last
                // Carry into the MSB, needed for signed overflow.
                logic m_q;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        m_q <= 1'b0;
                    end else if (advance) begin
                        m_q <= cc[GROUP-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[L-1].v_q;
    assign sum       = stg[L-1].s_q;
    assign cout      = stg[L-1].c_q;
    assign ovf       = stg[L-1].c_q ^ stg[L-1].last.m_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder in three configurations:
// (16,4) latency 4, (8,8) latency 1, (12,1) latency 12.
module tb_cla_pipe_adder;

    logic clk;
    logic rst_n;

    logic [15:0] ta [3];
    logic [15:0] tbv [3];
    logic        tcin [3];
    logic        tsub [3];
    logic        tvalid [3];
    logic        tord [3];

    logic        oinrdy [3];
    logic        ovalid [3];
    logic        ocout [3];
    logic        oovf [3];
    logic [15:0] osum [3];

    logic [15:0] s0;
    logic [7:0]  s1;
    logic [11:0] s2;

    int nchk = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign osum[0] = s0;
    assign osum[1] = {8'h00, s1};
    assign osum[2] = {4'h0, s2};

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(tvalid[0]), .in_ready(oinrdy[0]),
        .a(ta[0]), .b(tbv[0]), .cin(tcin[0]), .sub(tsub[0]),
        .out_valid(ovalid[0]), .out_ready(tord[0]),
        .sum(s0), .cout(ocout[0]), .ovf(oovf[0])
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(tvalid[1]), .in_ready(oinrdy[1]),
        .a(ta[1][7:0]), .b(tbv[1][7:0]), .cin(tcin[1]), .sub(tsub[1]),
        .out_valid(ovalid[1]), .out_ready(tord[1]),
        .sum(s1), .cout(ocout[1]), .ovf(oovf[1])
    );

    cla_pipe_adder #(.WIDTH(12), .GROUP(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(tvalid[2]), .in_ready(oinrdy[2]),
        .a(ta[2][11:0]), .b(tbv[2][11:0]), .cin(tcin[2]), .sub(tsub[2]),
        .out_valid(ovalid[2]), .out_ready(tord[2]),
        .sum(s2), .cout(ocout[2]), .ovf(oovf[2])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b,
                                          logic ci, logic sb);
        logic [31:0] m, lm, aa, bb, f, lo, c0;
        logic        co, cm;
        m  = (32'd1 << w) - 32'd1;
        lm = (32'd1 << (w - 1)) - 32'd1;
        c0 = {31'd0, sb | ci};
        aa = {16'd0, a} & m;
        bb = (sb ? ~{16'd0, b} : {16'd0, b}) & m;
        f  = aa + bb + c0;
        lo = (aa & lm) + (bb & lm) + c0;
        co = f[w];
        cm = lo[w-1];
        f  = f & m;
        return {co ^ cm, co, f[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 12;
        logic [17:0] q [$];
        logic        hold_p = 1'b0;
        logic [15:0] hold_s = 16'h0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                hold_p <= 1'b0;
            end else begin
                chk($sformatf("in_ready%0d", g), {31'd0, oinrdy[g]},
                    {31'd0, !ovalid[g] || tord[g]});
                if (hold_p)
                    chk($sformatf("hold%0d", g), {15'd0, ovalid[g], osum[g]},
                        {15'd0, 1'b1, hold_s});
                hold_p <= ovalid[g] && !tord[g];
                hold_s <= osum[g];
                if (ovalid[g] && tord[g]) begin
                    chk($sformatf("sb_avail%0d", g), {31'd0, q.size() != 0}, 32'd1);
                    if (q.size() != 0)
                        chk($sformatf("result%0d", g),
                            {14'd0, oovf[g], ocout[g], osum[g]},
                            {14'd0, q.pop_front()});
                end
                if (tvalid[g] && oinrdy[g])
                    q.push_back(model(W, ta[g], tbv[g], tcin[g], tsub[g]));
            end
        end
    end

    // Drive one set into an empty pipe and check the exact cycle it appears.
    task automatic lat(int g, int l, logic [15:0] a, logic [15:0] b, logic ci,
                       logic sb, logic [15:0] es, logic ec, logic eo, bit idle);
        if (idle) repeat (l + 2) begin @(posedge clk); #1; end
        tord[g]   = 1'b1;
        tvalid[g] = 1'b1;
        ta[g]     = a;
        tbv[g]    = b;
        tcin[g]   = ci;
        tsub[g]   = sb;
        @(negedge clk);
        chk("lat_inrdy", {31'd0, oinrdy[g]}, 32'd1);
        @(posedge clk); #1;
        tvalid[g] = 1'b0;
        for (int i = 1; i <= l; i++) begin
            chk($sformatf("lat%0d_valid_c%0d", g, i), {31'd0, ovalid[g]},
                {31'd0, i == l});
            if (i < l) begin @(posedge clk); #1; end
        end
        chk($sformatf("lat%0d_sum", g), {16'd0, osum[g]}, {16'd0, es});
        chk($sformatf("lat%0d_cout", g), {31'd0, ocout[g]}, {31'd0, ec});
        chk($sformatf("lat%0d_ovf", g), {31'd0, oovf[g]}, {31'd0, eo});
    endtask

    task automatic rand_run(int g, int n);
        int  acc;
        int  cyc;
        bit  fire;
        acc = 0;
        cyc = 0;
        tvalid[g] = 1'b0;
        while (acc < n && cyc < 40000) begin
            @(negedge clk);
            fire = tvalid[g] && oinrdy[g];
            @(posedge clk); #1;
            cyc++;
            if (fire) acc++;
            if (fire || !tvalid[g]) begin
                tvalid[g] = ($urandom_range(0, 9) < 7) && (acc < n);
                ta[g]     = 16'($urandom);
                tbv[g]    = 16'($urandom);
                tcin[g]   = 1'($urandom);
                tsub[g]   = 1'($urandom);
            end
            tord[g] = ($urandom_range(0, 3) != 0);
        end
        tvalid[g] = 1'b0;
        tord[g]   = 1'b1;
        chk($sformatf("rnd%0d_accepted", g), acc, n);
        repeat (20) begin @(posedge clk); #1; end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, stall, rel_cnt, rel_out, nrdy0;
        bit started, fire;
        logic [15:0] held;

        for (int g = 0; g < 3; g++) begin
            tvalid[g] = 1'b0;
            tord[g]   = 1'b1;
            ta[g]     = 16'h0;
            tbv[g]    = 16'h0;
            tcin[g]   = 1'b0;
            tsub[g]   = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int g = 0; g < 3; g++) begin
            chk("rst_valid", {31'd0, ovalid[g]}, 32'd0);
            chk("rst_sum", {16'd0, osum[g]}, 32'd0);
            chk("rst_cout", {31'd0, ocout[g]}, 32'd0);
            chk("rst_ovf", {31'd0, oovf[g]}, 32'd0);
            chk("rst_inrdy", {31'd0, oinrdy[g]}, 32'd1);
        end
        rst_n = 1'b1;

        lat(0, 4, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        lat(0, 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat(0, 4, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        lat(0, 4, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        lat(0, 4, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        lat(0, 4, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        lat(0, 4, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat(1, 1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b1);
        lat(1, 1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1);
        lat(2, 12, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat(2, 12, 16'h0800, 16'h0001, 1'b0, 1'b1, 16'h07FF, 1'b1, 1'b1, 1'b1);

        // Backpressure: 8 back-to-back sets, 3-cycle stall at first result.
        repeat (6) begin @(posedge clk); #1; end
        sent = 0; stall = 0; rel_cnt = 0; rel_out = 0; nrdy0 = 0;
        started = 1'b0;
        held = 16'h0;
        tord[0] = 1'b1; tvalid[0] = 1'b1;
        ta[0] = 16'h0; tbv[0] = 16'h0; tcin[0] = 1'b0; tsub[0] = 1'b0;
        for (int cyc = 0; cyc < 60 && rel_cnt < 8; cyc++) begin
            @(negedge clk);
            fire = tvalid[0] && oinrdy[0];
            if (!oinrdy[0]) nrdy0++;
            if (!tord[0]) begin
                chk("bp_inrdy", {31'd0, oinrdy[0]}, 32'd0);
                chk("bp_hold", {15'd0, ovalid[0], osum[0]}, {15'd0, 1'b1, held});
            end else if (started) begin
                rel_cnt++;
                if (ovalid[0]) rel_out++;
            end
            @(posedge clk); #1;
            if (fire) sent++;
            if (sent < 8) begin
                ta[0]  = 16'(sent);
                tbv[0] = 16'(32'h1000 * sent);
            end else begin
                tvalid[0] = 1'b0;
            end
            if (!started && ovalid[0]) begin
                started = 1'b1;
                held = osum[0];
            end
            if (started && stall < 3) begin
                tord[0] = 1'b0;
                stall++;
            end else begin
                tord[0] = 1'b1;
            end
        end
        tvalid[0] = 1'b0;
        tord[0] = 1'b1;
        chk("bp_sent", sent, 8);
        chk("bp_stalls", stall, 3);
        chk("bp_inrdy_low_cycles", nrdy0, 3);
        chk("bp_rate", rel_out, 8);
        repeat (8) begin @(posedge clk); #1; end
        chk("bp_drain", mon[0].q.size(), 0);

        // Reset with three sets in flight.
        for (int i = 0; i < 3; i++) begin
            tvalid[0] = 1'b1;
            ta[0] = 16'(32'h0100 * (i + 1));
            tbv[0] = 16'h0011;
            tcin[0] = 1'b0;
            tsub[0] = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        ta[0] = 16'hDEAD;
        @(posedge clk); #1;
        chk("mrst_valid", {31'd0, ovalid[0]}, 32'd0);
        chk("mrst_sum", {16'd0, osum[0]}, 32'd0);
        chk("mrst_cout", {31'd0, ocout[0]}, 32'd0);
        chk("mrst_ovf", {31'd0, oovf[0]}, 32'd0);
        chk("mrst_inrdy", {31'd0, oinrdy[0]}, 32'd1);
        rst_n = 1'b1;
        lat(0, 4, 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        chk("mrst_drain", mon[0].q.size(), 0);

        fork
            rand_run(0, 10000);
            rand_run(1, 10000);
            rand_run(2, 10000);
        join
        chk("rnd_drain0", mon[0].q.size(), 0);
        chk("rnd_drain1", mon[1].q.size(), 0);
        chk("rnd_drain2", mon[2].q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
